uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/byte_fifo.sv | 73 +++++++
 rtl/uart_rx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the serial receive path
//
// Purpose: receiver state encoding and default baud divisor, shared by
//          uart_rx_fifo and anything that inspects its state.
// Ports:   none (package).
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE  = 3'd0;
  localparam rx_state_t RX_START = 3'd1;
  localparam rx_state_t RX_DATA  = 3'd2;
  localparam rx_state_t RX_STOP  = 3'd3;
  localparam rx_state_t RX_BREAK = 3'd4;

  // 50 MHz sysclk / 9600 baud
  localparam int CLKS_9600_AT_50M = 5208;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous show-ahead byte FIFO
//
// Purpose: small power-of-two FIFO whose head byte is always presented on
//          rdata while not empty.
// Ports:   sysclk, reset (async, active-high)
//          push, wdata  - write request, ignored while full
//          pop          - advance head, ignored while empty
//          rdata        - head byte (keeps its last value once empty)
//          empty, full  - occupancy flags
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= 8'h00;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      // Registered head: if the next head is the slot being written right
      // now, the memory does not hold it yet, so bypass wdata.
      if (count_nxt != '0) begin
        if (do_push && (rd_ptr_nxt == wr_ptr)) rdata <= wdata;
        else                                    rdata <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver feeding a show-ahead byte FIFO
//
// Purpose: synchronise the raw RX line, frame 8N1 bytes (LSB first, mid-bit
//          sampling) and buffer good bytes for the downstream text controller.
// Ports:   sysclk, reset (async, active-high)
//          serial_in  - raw RX line, idle high, asynchronous
//          rd_en      - pop request, ignored while empty
//          rd_data    - head byte, valid while empty=0
//          empty/full - FIFO occupancy
//          busy       - receiver not idle
//          frame_err  - one-cycle pulse on a bad stop bit
//          overflow   - one-cycle pulse when a good byte is dropped (FIFO full)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_9600_AT_50M,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serial_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       frame_err,
  output logic       overflow
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1;
  logic          rx_s;
  rx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_done;
  logic          half_done;
  logic          stop_sample;
  logic          push;

  assign busy        = (state != RX_IDLE);
  assign bit_done    = (baud_cnt == BIT_LAST);
  assign half_done   = (baud_cnt == HALF_LAST);
  assign stop_sample = (state == RX_STOP) && bit_done;
  // Full is judged on the pre-pop count so push and pop stay independent.
  assign push        = stop_sample && rx_s && !full;

  // Two-flop synchroniser, reset to the idle-high line level.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= serial_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= 8'h00;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= stop_sample && !rx_s;
      overflow  <= stop_sample && rx_s && full;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (half_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            // Line back high at mid start bit: treat as a glitch.
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_done) begin
            baud_cnt       <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state   <= RX_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            // A low stop bit parks in BREAK so a held-low line reports once.
            state    <= rx_s ? RX_IDLE : RX_BREAK;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .sysclk (sysclk),
    .reset  (reset),
    .push   (push),
    .wdata  (shreg),
    .pop    (rd_en),
    .rdata  (rd_data),
    .empty  (empty),
    .full   (full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       sysclk    = 1'b0;
  logic       reset     = 1'b1;
  logic       serial_in = 1'b1;
  logic       rd_en     = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       busy;
  logic       frame_err;
  logic       overflow;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (2)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .serial_in (serial_in),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 sysclk = ~sysclk;

  int n_assert = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ovf_cnt  = 0;
  int both_cnt = 0;
  int exp_fe   = 0;
  int exp_ovf  = 0;
  logic [7:0] model_q[$];
  logic       e_before;
  logic       e_after;

  always @(negedge sysclk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ovf_cnt++;
    if (frame_err && overflow) both_cnt++;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line-side transmitter. Start bit mid-sample lands 8 cycles after the
  // 2-cycle synchroniser, so the stop-bit sample edge is the 155th rising
  // edge after the start negedge; j==154 places rd_en on that edge.
  // reset_at >= 0 aborts the frame with a reset pulse at that cycle.
  task automatic send(input logic [7:0] d, input logic stop,
                      input bit pop_at_push, input int reset_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int j = 0; j < 10 * CPB; j++) begin
      if (reset_at >= 0 && j == reset_at) begin
        serial_in = 1'b1;
        reset     = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        return;
      end
      if (j % CPB == 0) begin
        serial_in = fr[0];
        fr        = fr >> 1;
      end
      rd_en = pop_at_push && (j == 154);
      if (j == 154) e_before = empty;
      if (j == 155) e_after  = empty;
      @(negedge sysclk);
    end
    rd_en = 1'b0;
  endtask

  // Reference: a good byte enters if the queue was not full before any
  // coincident pop; a bad stop bit always reports and never enters.
  function automatic void model_frame(input logic [7:0] d, input logic stop, input bit popped);
    bit was_full;
    was_full = (model_q.size() == DEPTH);
    if (!stop)         exp_fe++;
    else if (was_full) exp_ovf++;
    if (popped && model_q.size() > 0) void'(model_q.pop_front());
    if (stop && !was_full) model_q.push_back(d);
  endfunction

  task automatic frame(input logic [7:0] d, input logic stop, input bit pop_at_push);
    send(d, stop, pop_at_push, -1);
    model_frame(d, stop, pop_at_push);
    serial_in = 1'b1;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge sysclk);
    rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic check_state(input string tag);
    chk1({tag, ".empty"}, empty, model_q.size() == 0);
    chk1({tag, ".full"}, full, model_q.size() == DEPTH);
    if (model_q.size() > 0) chk8({tag, ".rd_data"}, rd_data, model_q[0]);
    chki({tag, ".frame_err_count"}, fe_cnt, exp_fe);
    chki({tag, ".overflow_count"}, ovf_cnt, exp_ovf);
    chk1({tag, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic       st;

    repeat (3) @(negedge sysclk);
    chk8("reset.rd_data", rd_data, 8'h00);
    chk1("reset.empty", empty, 1'b1);
    chk1("reset.full", full, 1'b0);
    chk1("reset.busy", busy, 1'b0);
    chk1("reset.frame_err", frame_err, 1'b0);
    chk1("reset.overflow", overflow, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge sysclk);

    // Single good byte and push latency
    frame(8'h41, 1'b1, 1'b0);
    chk1("t1.empty_at_sample", e_before, 1'b1);
    chk1("t1.empty_after_sample", e_after, 1'b0);
    check_state("t1");
    pop_one();
    chk1("t1.empty_after_pop", empty, 1'b1);

    // Short low glitch is rejected at mid start bit
    serial_in = 1'b0;
    repeat (4) @(negedge sysclk);
    serial_in = 1'b1;
    chk1("t2.busy_in_start", busy, 1'b1);
    repeat (20) @(negedge sysclk);
    check_state("t2");

    // Bad stop bit, held break, then a clean frame
    send(8'h55, 1'b0, 1'b0, -1);
    model_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge sysclk);
    chk1("t3.busy_in_break", busy, 1'b1);
    chki("t3.single_frame_err", fe_cnt, 1);
    serial_in = 1'b1;
    repeat (5) @(negedge sysclk);
    check_state("t3.break");
    frame(8'hAA, 1'b1, 1'b0);
    check_state("t3.aa");
    pop_one();

    // Fill to full, overflow on the fifth, drain in order
    for (int i = 1; i <= 5; i++) begin
      frame(8'(i), 1'b1, 1'b0);
      if (i == 4) chk1("t4.full_after_4", full, 1'b1);
    end
    check_state("t4.after_5");
    for (int i = 0; i < 4; i++) begin
      check_state("t4.drain");
      pop_one();
    end
    chk1("t4.empty_after_drain", empty, 1'b1);

    // Reset in the middle of data bit 3 discards the frame
    send(8'hC3, 1'b1, 1'b0, 4 * CPB + 8);
    model_q.delete();
    repeat (5) @(negedge sysclk);
    chk1("t5.busy_after_reset", busy, 1'b0);
    chk1("t5.empty_after_reset", empty, 1'b1);
    frame(8'h3C, 1'b1, 1'b0);
    check_state("t5");
    pop_one();
    chk1("t5.empty_after_pop", empty, 1'b1);

    // Pop coinciding with push: 3 held bytes, then 4 held bytes (full)
    for (int i = 0; i < 3; i++) frame(8'($urandom), 1'b1, 1'b0);
    frame(8'hE7, 1'b1, 1'b1);
    check_state("t6.three");
    frame(8'h5A, 1'b1, 1'b0);
    chk1("t6.full", full, 1'b1);
    frame(8'h99, 1'b1, 1'b1);
    check_state("t6.full_pop");
    while (model_q.size() > 0) begin
      check_state("t6.drain");
      pop_one();
    end

    // Randomized frames, stop bits and pops
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      frame(d, st, 1'b0);
      check_state("rand.frame");
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        check_state("rand.pop");
      end
      repeat ($urandom_range(0, 8)) @(negedge sysclk);
    end

    chki("never_both_pulses", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
